dsp_op_sequencer: RTL and testbench

Initiator-side controller for the DSP slice. It accepts operation commands over a valid/ready interface and drives the DSP's A/B/D/C operand ports, OPMODE and the clock-enable and reset controls. It waits out the DSP pipeline latency, then captures P/CARRYOUT into a result register held under valid/ready backpressure. It sits between the datapath control logic and one DSP instance, with one operation outstanding at a time.

---
 rtl/dsp_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_dsp_op_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_op_sequencer.sv
// Command sequencer for one DSP slice: issues operands/OPMODE, waits out the
// pipeline latency, then holds P/CARRYOUT in a result register under backpressure.
module dsp_op_sequencer #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [17:0] cmd_a,
    input  logic [17:0] cmd_b,
    input  logic [17:0] cmd_d,
    input  logic [47:0] cmd_c,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [47:0] dsp_c,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_p,
    output logic        res_carry,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam int unsigned CNT_MAX = (LATENCY > CLR_CYCLES) ? LATENCY : CLR_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] OP_MAC   = 2'b00;
    localparam logic [1:0] OP_MSUB  = 2'b01;
    localparam logic [1:0] OP_PASSC = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [7:0] OPM_MAC   = 8'b00011101;
    localparam logic [7:0] OPM_MSUB  = 8'b10001101;
    localparam logic [7:0] OPM_PASSC = 8'b00001100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_CLR
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cmd_ready_q;
    logic [17:0]        dsp_a_q;
    logic [17:0]        dsp_b_q;
    logic [17:0]        dsp_d_q;
    logic [47:0]        dsp_c_q;
    logic [7:0]         dsp_opmode_q;
    logic               dsp_ce_q;
    logic               dsp_rst_q;
    logic               res_valid_q;
    logic [47:0]        res_p_q;
    logic               res_carry_q;
    logic               busy_q;
    logic [15:0]        op_count_q;

    function automatic logic [7:0] opmode_for(input logic [1:0] op);
        case (op)
            OP_MAC:   return OPM_MAC;
            OP_MSUB:  return OPM_MSUB;
            OP_PASSC: return OPM_PASSC;
            default:  return 8'b00000000;
        endcase
    endfunction

    // Control FSM; cnt_q counts down the remaining pipeline or clear cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b1;
            dsp_a_q      <= '0;
            dsp_b_q      <= '0;
            dsp_d_q      <= '0;
            dsp_c_q      <= '0;
            dsp_opmode_q <= 8'b00000000;
            dsp_ce_q     <= 1'b0;
            dsp_rst_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_p_q      <= '0;
            res_carry_q  <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        dsp_ce_q    <= 1'b1;
                        if (cmd_op == OP_CLEAR) begin
                            dsp_rst_q <= 1'b1;
                            cnt_q     <= CNT_W'(CLR_CYCLES - 1);
                            state_q   <= ST_CLR;
                        end else begin
                            dsp_a_q      <= cmd_a;
                            dsp_b_q      <= cmd_b;
                            dsp_d_q      <= cmd_d;
                            dsp_c_q      <= cmd_c;
                            dsp_opmode_q <= opmode_for(cmd_op);
                            cnt_q        <= CNT_W'(LATENCY - 1);
                            state_q      <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        res_p_q     <= dsp_p;
                        res_carry_q <= dsp_carryout;
                        res_valid_q <= 1'b1;
                        dsp_ce_q    <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        dsp_rst_q   <= 1'b0;
                        dsp_ce_q    <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign dsp_a      = dsp_a_q;
    assign dsp_b      = dsp_b_q;
    assign dsp_d      = dsp_d_q;
    assign dsp_c      = dsp_c_q;
    assign dsp_opmode = dsp_opmode_q;
    assign dsp_ce     = dsp_ce_q;
    assign dsp_rst    = dsp_rst_q;
    assign res_valid  = res_valid_q;
    assign res_p      = res_p_q;
    assign res_carry  = res_carry_q;
    assign busy       = busy_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Directed bench for dsp_op_sequencer with a one-register DSP stand-in.
module tb_dsp_op_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [17:0] cmd_a = '0;
    logic [17:0] cmd_b = '0;
    logic [17:0] cmd_d = '0;
    logic [47:0] cmd_c = '0;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [17:0] dsp_d;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce;
    logic        dsp_rst;
    logic [47:0] dsp_p = '0;
    logic        dsp_carryout = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_p;
    logic        res_carry;
    logic        busy;
    logic [15:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    dsp_op_sequencer #(.LATENCY(2), .CLR_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_c(cmd_c),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst),
        .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_p(res_p), .res_carry(res_carry),
        .busy(busy), .op_count(op_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [47:0] sx(input logic [17:0] v);
        return {{30{v[17]}}, v};
    endfunction

    // DSP stand-in: P registers the selected function whenever CE is high.
    always @(posedge CLK) begin
        if (dsp_rst) begin
            dsp_p        <= '0;
            dsp_carryout <= 1'b0;
        end else if (dsp_ce) begin
            case (dsp_opmode)
                8'b00011101: dsp_p <= (sx(dsp_d) + sx(dsp_b)) * sx(dsp_a) + dsp_c;
                8'b10001101: dsp_p <= dsp_c - sx(dsp_b) * sx(dsp_a);
                8'b00001100: dsp_p <= dsp_c;
                default:     dsp_p <= '0;
            endcase
            dsp_carryout <= (dsp_opmode == 8'b10001101);
        end
    end

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [17:0] a, input logic [17:0] b,
                             input logic [17:0] d, input logic [47:0] c);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d; cmd_c = c; cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_cmp++; if ({dsp_ce, dsp_rst} !== 2'b00) begin n_err++; $display("FAIL rst_ce_rst got %b exp 00", {dsp_ce, dsp_rst}); end
        n_cmp++; if (dsp_opmode !== 8'h00) begin n_err++; $display("FAIL rst_opmode got %h exp 00", dsp_opmode); end
        n_cmp++; if (op_count !== 16'h0) begin n_err++; $display("FAIL rst_op_count got %h exp 0", op_count); end
        n_cmp++; if (res_p !== 48'h0) begin n_err++; $display("FAIL rst_res_p got %h exp 0", res_p); end
    endtask

    task automatic test_mac();
        drive_cmd(2'b00, 18'd14, 18'd15, 18'd11, 48'd10);
        step();
        cmd_valid = 1'b0;
        n_cmp++; if (dsp_opmode !== 8'b00011101) begin n_err++; $display("FAIL mac_opmode got %b exp 00011101", dsp_opmode); end
        n_cmp++; if ({dsp_ce, cmd_ready, busy} !== 3'b101) begin n_err++; $display("FAIL mac_issue ce/rdy/busy got %b exp 101", {dsp_ce, cmd_ready, busy}); end
        n_cmp++; if (dsp_a !== 18'd14 || dsp_d !== 18'd11) begin n_err++; $display("FAIL mac_operands got a=%0d d=%0d exp 14 11", dsp_a, dsp_d); end
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL mac_early_valid got %b exp 0", res_valid); end
        step();
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL mac_valid got %b exp 1", res_valid); end
        n_cmp++; if (res_p !== 48'd374) begin n_err++; $display("FAIL mac_res_p got %0d exp 374", res_p); end
        n_cmp++; if (op_count !== 16'd1) begin n_err++; $display("FAIL mac_op_count got %0d exp 1", op_count); end
        n_cmp++; if (dsp_ce !== 1'b0) begin n_err++; $display("FAIL mac_done_ce got %b exp 0", dsp_ce); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_cmp++; if ({res_valid, cmd_ready, busy} !== 3'b010) begin n_err++; $display("FAIL mac_return valid/rdy/busy got %b exp 010", {res_valid, cmd_ready, busy}); end
    endtask

    task automatic test_msub();
        drive_cmd(2'b01, 18'd14, 18'd15, 18'd0, 48'd10);
        step();
        cmd_valid = 1'b0;
        n_cmp++; if (dsp_opmode !== 8'b10001101) begin n_err++; $display("FAIL msub_opmode got %b exp 10001101", dsp_opmode); end
        step(); step();
        n_cmp++; if (res_p !== 48'hFFFF_FFFF_FF38) begin n_err++; $display("FAIL msub_res_p got %h exp ffffffffff38", res_p); end
        n_cmp++; if (res_carry !== 1'b1) begin n_err++; $display("FAIL msub_carry got %b exp 1", res_carry); end
        n_cmp++; if (op_count !== 16'd2) begin n_err++; $display("FAIL msub_op_count got %0d exp 2", op_count); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_passc_backpressure();
        drive_cmd(2'b10, 18'd0, 18'd0, 18'd0, 48'd10);
        step();
        cmd_valid = 1'b0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if ({res_valid, cmd_ready} !== 2'b10) begin n_err++; $display("FAIL bp_hold[%0d] valid/rdy got %b exp 10", i, {res_valid, cmd_ready}); end
            n_cmp++; if (res_p !== 48'd10 || res_carry !== 1'b0) begin n_err++; $display("FAIL bp_res[%0d] got p=%0d c=%b exp 10 0", i, res_p, res_carry); end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_cmp++; if ({res_valid, cmd_ready, busy} !== 3'b010) begin n_err++; $display("FAIL bp_release valid/rdy/busy got %b exp 010", {res_valid, cmd_ready, busy}); end
        n_cmp++; if (op_count !== 16'd3) begin n_err++; $display("FAIL bp_op_count got %0d exp 3", op_count); end
    endtask

    task automatic test_clear();
        drive_cmd(2'b11, 18'd5, 18'd6, 18'd7, 48'd99);
        step();
        cmd_valid = 1'b0;
        n_cmp++; if ({dsp_rst, dsp_ce, cmd_ready} !== 3'b110) begin n_err++; $display("FAIL clr_c1 rst/ce/rdy got %b exp 110", {dsp_rst, dsp_ce, cmd_ready}); end
        n_cmp++; if (dsp_opmode !== 8'b00001100 || dsp_c !== 48'd10) begin n_err++; $display("FAIL clr_keep opmode=%b c=%0d exp 00001100 10", dsp_opmode, dsp_c); end
        step();
        n_cmp++; if ({dsp_rst, dsp_ce, res_valid} !== 3'b110) begin n_err++; $display("FAIL clr_c2 rst/ce/valid got %b exp 110", {dsp_rst, dsp_ce, res_valid}); end
        step();
        n_cmp++; if ({dsp_rst, dsp_ce, cmd_ready, res_valid} !== 4'b0010) begin n_err++; $display("FAIL clr_end rst/ce/rdy/valid got %b exp 0010", {dsp_rst, dsp_ce, cmd_ready, res_valid}); end
        n_cmp++; if (op_count !== 16'd3) begin n_err++; $display("FAIL clr_op_count got %0d exp 3", op_count); end
    endtask

    task automatic test_ignored_cmd();
        drive_cmd(2'b00, 18'd1, 18'd2, 18'd3, 48'd4);
        step();
        drive_cmd(2'b10, 18'd0, 18'd0, 18'd0, 48'd77);
        res_ready = 1'b1;
        step();
        n_cmp++; if (cmd_ready !== 1'b0 || dsp_c !== 48'd4) begin n_err++; $display("FAIL ign_wait rdy=%b c=%0d exp 0 4", cmd_ready, dsp_c); end
        step();
        n_cmp++; if (res_valid !== 1'b1 || res_p !== 48'd9) begin n_err++; $display("FAIL ign_res valid=%b p=%0d exp 1 9", res_valid, res_p); end
        n_cmp++; if (dsp_c !== 48'd4) begin n_err++; $display("FAIL ign_done_c got %0d exp 4", dsp_c); end
        step();
        n_cmp++; if (cmd_ready !== 1'b1 || dsp_c !== 48'd4) begin n_err++; $display("FAIL ign_idle rdy=%b c=%0d exp 1 4", cmd_ready, dsp_c); end
        step();
        cmd_valid = 1'b0;
        n_cmp++; if (dsp_c !== 48'd77 || dsp_opmode !== 8'b00001100) begin n_err++; $display("FAIL ign_accept c=%0d opm=%b exp 77 00001100", dsp_c, dsp_opmode); end
        step(); step();
        n_cmp++; if (res_valid !== 1'b1 || res_p !== 48'd77 || op_count !== 16'd5) begin n_err++; $display("FAIL ign_second valid=%b p=%0d cnt=%0d exp 1 77 5", res_valid, res_p, op_count); end
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        drive_cmd(2'b00, 18'd14, 18'd15, 18'd11, 48'd10);
        step();
        cmd_valid = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        n_cmp++; if ({cmd_ready, busy, dsp_ce, dsp_rst, res_valid} !== 5'b10000) begin n_err++; $display("FAIL rmw_ctrl rdy/busy/ce/rst/valid got %b exp 10000", {cmd_ready, busy, dsp_ce, dsp_rst, res_valid}); end
        n_cmp++; if (dsp_a !== 18'd0 || dsp_b !== 18'd0 || dsp_d !== 18'd0 || dsp_c !== 48'd0 || dsp_opmode !== 8'h00) begin n_err++; $display("FAIL rmw_operands a=%0d b=%0d d=%0d c=%0d opm=%h exp all 0", dsp_a, dsp_b, dsp_d, dsp_c, dsp_opmode); end
        n_cmp++; if (res_p !== 48'd0 || res_carry !== 1'b0 || op_count !== 16'd0) begin n_err++; $display("FAIL rmw_result p=%0d c=%b cnt=%0d exp 0 0 0", res_p, res_carry, op_count); end
        step(); step();
        n_cmp++; if (res_valid !== 1'b0 || op_count !== 16'd0) begin n_err++; $display("FAIL rmw_after valid=%b cnt=%0d exp 0 0", res_valid, op_count); end
    endtask

    task automatic test_wrap();
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        step();
        n_cmp++; if (op_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload got %h exp ffff", op_count); end
        drive_cmd(2'b00, 18'd14, 18'd15, 18'd11, 48'd10);
        step();
        cmd_valid = 1'b0;
        step(); step();
        n_cmp++; if (op_count !== 16'h0000 || res_p !== 48'd374) begin n_err++; $display("FAIL wrap_count cnt=%h p=%0d exp 0000 374", op_count, res_p); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_rst_with_handshake();
        drive_cmd(2'b00, 18'd1, 18'd2, 18'd3, 48'd4);
        RST = 1'b1;
        step();
        cmd_valid = 1'b0;
        RST = 1'b0;
        n_cmp++; if ({busy, cmd_ready, dsp_ce} !== 3'b010) begin n_err++; $display("FAIL rsths_ctrl busy/rdy/ce got %b exp 010", {busy, cmd_ready, dsp_ce}); end
        n_cmp++; if (dsp_c !== 48'd0 || dsp_opmode !== 8'h00) begin n_err++; $display("FAIL rsths_dropped c=%0d opm=%h exp 0 00", dsp_c, dsp_opmode); end
        step();
        n_cmp++; if (busy !== 1'b0 || dsp_ce !== 1'b0) begin n_err++; $display("FAIL rsths_idle busy=%b ce=%b exp 0 0", busy, dsp_ce); end
    endtask

    initial begin
        test_reset();
        test_mac();
        test_msub();
        test_passc_backpressure();
        test_clear();
        test_ignored_cmd();
        test_reset_mid_wait();
        test_wrap();
        test_rst_with_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
